// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and result conventions for the MDU
package mdu_pkg;

  // EX-stage op encoding: bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Divide by zero: hi returns the raw dividend, lo is filled with this bit.
  localparam bit DIV0_HI_IS_DIVIDEND = 1'b1;
  localparam logic DIV0_LO_BIT       = 1'b1;

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - EX-stage request/result bundle for the iterative MDU
// master: EX stage (drives start/op/a/b/cancel); slave: mdu_iter (drives stallreq/done/hi/lo).
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stallreq;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input stallreq, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output stallreq, done, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - restoring divider datapath, one quotient bit per step
// Ports: clk_i/rst_i (sync, active-high); load_i captures dividend_i/divisor_i magnitudes;
// step_i advances one bit; rem_d_o/quo_d_o are the values the current step produces.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_d_o,
  output logic [WIDTH-1:0] quo_d_o
);
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH:0]   trial;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_d_o = trial[WIDTH-1:0];
      quo_d_o = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d_o = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d_o = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_d_o;
      quo_q  <= quo_d_o;
    end
  end
endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit producing HI/LO for the EX stage
// Ports: clk, rst (sync, active-high); bus (mdu_iter_if.slave): start/op/a/b/cancel in,
// stallreq (combinational), done (one-cycle pulse), hi/lo (registered result) out.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit MUL_SINGLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  mdu_iter_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sa_q, sb_q, bz_q;
  logic [WIDTH-1:0]   a_q, mcand_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               done_q;

  logic               sa_d, sb_d, accept;
  logic [WIDTH-1:0]   amag_d, bmag_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] prod_d, prod1_d, mul_res_d, mul1_res_d;
  logic [WIDTH-1:0]   rem_d, quo_d, rem_res_d, quo_res_d;

  always_comb begin
    sa_d   = is_signed_op(bus.op) & bus.a[WIDTH-1];
    sb_d   = is_signed_op(bus.op) & bus.b[WIDTH-1];
    // Magnitudes stay WIDTH-bit unsigned, so |most-negative| is exact.
    amag_d = sa_d ? -bus.a : bus.a;
    bmag_d = sb_d ? -bus.b : bus.b;
    accept = (state_q == ST_IDLE) && bus.start && !bus.cancel;

    // Shift-add: the multiplier sits in the low half of prod_q and is
    // consumed LSB first while the partial product shifts in from the top.
    mul_sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d     = {mul_sum_d, prod_q[WIDTH-1:1]};
    mul_res_d  = (sa_q ^ sb_q) ? -prod_d : prod_d;

    prod1_d    = {{WIDTH{1'b0}}, amag_d} * {{WIDTH{1'b0}}, bmag_d};
    mul1_res_d = (sa_d ^ sb_d) ? -prod1_d : prod1_d;

    quo_res_d  = (sa_q ^ sb_q) ? -quo_d : quo_d;
    rem_res_d  = sa_q ? -rem_d : rem_d;
  end

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept && is_div_op(bus.op)),
    .step_i     (state_q == ST_DIV),
    .dividend_i (amag_d),
    .divisor_i  (bmag_d),
    .rem_d_o    (rem_d),
    .quo_d_o    (quo_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.cancel) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: if (bus.start) begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= (bus.b == '0);
            a_q     <= bus.a;
            mcand_q <= amag_d;
            prod_q  <= {{WIDTH{1'b0}}, bmag_d};
            cnt_q   <= '0;
            if (is_div_op(bus.op)) begin
              state_q <= ST_DIV;
            end else if (MUL_SINGLE) begin
              {hi_q, lo_q} <= mul1_res_d;
              done_q       <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_MUL;
            end
          end
          ST_MUL: begin
            prod_q <= prod_d;
            if (cnt_q == LAST_STEP) begin
              {hi_q, lo_q} <= mul_res_d;
              done_q       <= 1'b1;
              cnt_q        <= '0;
              state_q      <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DIV: begin
            if (cnt_q == LAST_STEP) begin
              if (bz_q) begin
                hi_q <= a_q;
                lo_q <= {WIDTH{DIV0_LO_BIT}};
              end else begin
                hi_q <= rem_res_d;
                lo_q <= quo_res_d;
              end
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Combinational on start so the issuing instruction stalls in its own cycle.
  assign bus.stallreq = !rst && !bus.cancel &&
                        (((state_q == ST_IDLE) && bus.start) ||
                         (state_q == ST_MUL) || (state_q == ST_DIV));
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter (32-bit iterative, 16-bit single-cycle multiply)
module tb_mdu_iter;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) m32 ();
  mdu_iter_if #(.WIDTH(16)) m16 ();

  mdu_iter #(.WIDTH(32), .MUL_SINGLE(1'b0)) dut32 (.clk(clk), .rst(rst), .bus(m32));
  mdu_iter #(.WIDTH(16), .MUL_SINGLE(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(m16));

  // Issues one op at the next negedge (cycle 0) and reports the cycle index
  // of the done pulse and of the first cycle with stallreq low (-1 = never).
  task automatic run_op(input bit use16, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int done_cyc, output int stall_low_cyc);
    logic st, dn;
    @(negedge clk);
    if (use16) begin
      m16.op = op; m16.a = a[15:0]; m16.b = b[15:0]; m16.start = 1'b1;
    end else begin
      m32.op = op; m32.a = a; m32.b = b; m32.start = 1'b1;
    end
    done_cyc = -1;
    stall_low_cyc = -1;
    for (int c = 0; c < 80; c++) begin
      #1;
      st = use16 ? m16.stallreq : m32.stallreq;
      dn = use16 ? m16.done : m32.done;
      if (!st && stall_low_cyc < 0) stall_low_cyc = c;
      if (dn) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
      m16.start = 1'b0;
      m32.start = 1'b0;
    end
    m16.start = 1'b0;
    m32.start = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (m32.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected %h", m32.hi, 32'h0); end
    n_vec++; if (m32.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected %h", m32.lo, 32'h0); end
    n_vec++; if (m32.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", m32.done); end
    n_vec++; if (m32.stallreq !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", m32.stallreq); end
    n_vec++; if (m16.hi !== 16'h0 || m16.lo !== 16'h0) begin n_err++; $display("FAIL reset_hilo16: got %h/%h expected 0/0", m16.hi, m16.lo); end
  endtask

  task automatic test_multu_max();
    int d, s;
    run_op(1'b0, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, s);
    n_vec++; if (d !== 33) begin n_err++; $display("FAIL multu_done_cycle: got %0d expected 33", d); end
    n_vec++; if (s !== 33) begin n_err++; $display("FAIL multu_stall_low_cycle: got %0d expected 33", s); end
    n_vec++; if (m32.hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h expected %h", m32.hi, 32'hFFFF_FFFE); end
    n_vec++; if (m32.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h expected %h", m32.lo, 32'h1); end
  endtask

  task automatic test_back_to_back();
    int d, s;
    run_op(1'b0, MDU_MULT, 32'hFFFF_FFFD, 32'd7, d, s);
    n_vec++; if (d !== 33) begin n_err++; $display("FAIL b2b_mult_done: got %0d expected 33", d); end
    n_vec++; if (m32.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_mult_hi: got %h expected %h", m32.hi, 32'hFFFF_FFFF); end
    n_vec++; if (m32.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL b2b_mult_lo: got %h expected %h", m32.lo, 32'hFFFF_FFEB); end
    run_op(1'b0, MDU_DIV, 32'hFFFF_FFF9, 32'd2, d, s);
    n_vec++; if (d !== 33 || s !== 33) begin n_err++; $display("FAIL b2b_div_timing: got done %0d stall_low %0d expected 33 33", d, s); end
    n_vec++; if (m32.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL b2b_div_lo: got %h expected %h", m32.lo, 32'hFFFF_FFFD); end
    n_vec++; if (m32.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_div_hi: got %h expected %h", m32.hi, 32'hFFFF_FFFF); end
  endtask

  task automatic test_arith_edges();
    int d, s;
    run_op(1'b0, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, d, s);
    n_vec++; if (m32.lo !== 32'h8000_0000 || m32.hi !== 32'h0) begin n_err++; $display("FAIL div_minneg_m1: got hi %h lo %h expected 00000000 80000000", m32.hi, m32.lo); end
    run_op(1'b0, MDU_DIVU, 32'd5, 32'd0, d, s);
    n_vec++; if (d !== 33) begin n_err++; $display("FAIL divu_by0_latency: got %0d expected 33", d); end
    n_vec++; if (m32.hi !== 32'd5 || m32.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_by0: got hi %h lo %h expected 00000005 ffffffff", m32.hi, m32.lo); end
    run_op(1'b0, MDU_DIV, 32'hFFFF_FFF8, 32'd0, d, s);
    n_vec++; if (m32.hi !== 32'hFFFF_FFF8 || m32.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_by0_signed: got hi %h lo %h expected fffffff8 ffffffff", m32.hi, m32.lo); end
    run_op(1'b0, MDU_DIV, 32'd7, 32'hFFFF_FFFE, d, s);
    n_vec++; if (m32.lo !== 32'hFFFF_FFFD || m32.hi !== 32'd1) begin n_err++; $display("FAIL div_rem_sign: got hi %h lo %h expected 00000001 fffffffd", m32.hi, m32.lo); end
    run_op(1'b0, MDU_MULT, 32'h8000_0000, 32'h8000_0000, d, s);
    n_vec++; if (m32.hi !== 32'h4000_0000 || m32.lo !== 32'h0) begin n_err++; $display("FAIL mult_minneg_sq: got hi %h lo %h expected 40000000 00000000", m32.hi, m32.lo); end
    run_op(1'b0, MDU_MULT, 32'h8000_0000, 32'hFFFF_FFFF, d, s);
    n_vec++; if (m32.hi !== 32'h0 || m32.lo !== 32'h8000_0000) begin n_err++; $display("FAIL mult_minneg_m1: got hi %h lo %h expected 00000000 80000000", m32.hi, m32.lo); end
  endtask

  task automatic test_cancel();
    int d, s;
    bit seen;
    run_op(1'b0, MDU_MULTU, 32'd3, 32'd5, d, s);
    n_vec++; if (m32.lo !== 32'd15 || m32.hi !== 32'd0) begin n_err++; $display("FAIL cancel_prior: got hi %h lo %h expected 0 f", m32.hi, m32.lo); end
    seen = 1'b0;
    @(negedge clk);
    m32.op = MDU_DIV; m32.a = 32'd1000; m32.b = 32'd3; m32.start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m32.done) seen = 1'b1;
      @(negedge clk);
      m32.start = 1'b0;
    end
    m32.cancel = 1'b1;
    #1;
    if (m32.done) seen = 1'b1;
    n_vec++; if (m32.stallreq !== 1'b0) begin n_err++; $display("FAIL cancel_stall_c10: got %b expected 0", m32.stallreq); end
    @(negedge clk);
    m32.cancel = 1'b0;
    #1;
    n_vec++; if (m32.stallreq !== 1'b0) begin n_err++; $display("FAIL cancel_idle_c11: got %b expected 0", m32.stallreq); end
    n_vec++; if (m32.hi !== 32'd0 || m32.lo !== 32'd15) begin n_err++; $display("FAIL cancel_hilo_kept: got hi %h lo %h expected 0 f", m32.hi, m32.lo); end
    m32.op = MDU_DIVU; m32.a = 32'd100; m32.b = 32'd7; m32.start = 1'b1;
    #1;
    n_vec++; if (m32.stallreq !== 1'b1) begin n_err++; $display("FAIL cancel_restart_stall: got %b expected 1", m32.stallreq); end
    d = -1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        @(negedge clk);
        m32.start = 1'b0;
        #1;
      end
      if (m32.done) begin
        d = k;
        break;
      end
    end
    m32.start = 1'b0;
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL cancel_no_done: got %b expected 0", seen); end
    n_vec++; if (d !== 33) begin n_err++; $display("FAIL cancel_restart_done: got %0d expected 33", d); end
    n_vec++; if (m32.lo !== 32'd14 || m32.hi !== 32'd2) begin n_err++; $display("FAIL cancel_restart_result: got hi %h lo %h expected 2 e", m32.hi, m32.lo); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    m32.op = MDU_MULT; m32.a = 32'hFFFF_FFFD; m32.b = 32'd7; m32.start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      @(negedge clk);
      m32.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_vec++; if (m32.stallreq !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall: got %b expected 0", m32.stallreq); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (m32.hi !== 32'h0 || m32.lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_hilo: got hi %h lo %h expected 0 0", m32.hi, m32.lo); end
    n_vec++; if (m32.done !== 1'b0 || m32.stallreq !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl: got done %b stall %b expected 0 0", m32.done, m32.stallreq); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (m32.done) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done: got %b expected 0", seen); end
    @(negedge clk);
    m32.op = MDU_MULTU; m32.a = 32'd9; m32.b = 32'd9; m32.start = 1'b1; m32.cancel = 1'b1;
    #1;
    n_vec++; if (m32.stallreq !== 1'b0) begin n_err++; $display("FAIL start_cancel_stall: got %b expected 0", m32.stallreq); end
    @(negedge clk);
    m32.start = 1'b0; m32.cancel = 1'b0;
    #1;
    n_vec++; if (m32.stallreq !== 1'b0 || m32.done !== 1'b0) begin n_err++; $display("FAIL start_cancel_idle: got stall %b done %b expected 0 0", m32.stallreq, m32.done); end
  endtask

  task automatic test_single16();
    int d, s;
    run_op(1'b1, MDU_MULT, 32'h8000, 32'h8000, d, s);
    n_vec++; if (d !== 1 || s !== 1) begin n_err++; $display("FAIL s16_mult_timing: got done %0d stall_low %0d expected 1 1", d, s); end
    n_vec++; if (m16.hi !== 16'h4000 || m16.lo !== 16'h0000) begin n_err++; $display("FAIL s16_mult: got hi %h lo %h expected 4000 0000", m16.hi, m16.lo); end
    run_op(1'b1, MDU_MULTU, 32'hFFFF, 32'hFFFF, d, s);
    n_vec++; if (m16.hi !== 16'hFFFE || m16.lo !== 16'h0001) begin n_err++; $display("FAIL s16_multu: got hi %h lo %h expected fffe 0001", m16.hi, m16.lo); end
    run_op(1'b1, MDU_DIV, 32'd100, 32'd7, d, s);
    n_vec++; if (d !== 17 || s !== 17) begin n_err++; $display("FAIL s16_div_timing: got done %0d stall_low %0d expected 17 17", d, s); end
    n_vec++; if (m16.lo !== 16'd14 || m16.hi !== 16'd2) begin n_err++; $display("FAIL s16_div: got hi %h lo %h expected 0002 000e", m16.hi, m16.lo); end
  endtask

  initial begin
    m32.start = 1'b0; m32.cancel = 1'b0; m32.op = 2'b00; m32.a = '0; m32.b = '0;
    m16.start = 1'b0; m16.cancel = 1'b0; m16.op = 2'b00; m16.a = '0; m16.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_arith_edges();
    test_cancel();
    test_reset_mid();
    test_single16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
